// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a small valid/ready FIFO.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote of rx_s around each sample.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so it lands one cycle late.
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif
    localparam logic [CNT_WIDTH-1:0] LP_START_PT =
        CNT_WIDTH'(CLKS_PER_BIT / 2 - 1 + VOTE_LAG);
    localparam logic [CNT_WIDTH-1:0] LP_BIT_PT = CNT_WIDTH'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic [CNT_WIDTH-1:0] r_timer;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_flag;
    logic                 r_frame_flag;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_out;

    logic                 w_bit;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_frame_bad;
    logic                 w_par_x;
    logic                 w_par_bad;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic [PW-1:0]        w_rptr_nx;
    logic [DATA_BITS-1:0] w_head_nx;

    // Two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_rx_s  <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_h1;
    logic r_h2;

    // Two older copies of rx_s for the 2-of-3 vote
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= r_rx_s;
            r_h2 <= r_h1;
        end
    end

    assign w_bit = (r_rx_s & r_h1) | (r_rx_s & r_h2) | (r_h1 & r_h2);
`else
    assign w_bit = r_rx_s;
`endif

    assign w_tick      = (r_state == S_START) ? (r_timer == LP_START_PT)
                                              : (r_timer == LP_BIT_PT);
    assign w_last_stop = (r_state == S_STOP) && w_tick &&
                         (r_bit_cnt == 4'(STOP_BITS - 1));
    assign w_frame_bad = r_frame_flag | ~w_bit;
    assign w_par_x     = (^r_shift) ^ w_bit;
    assign w_par_bad   = (PARITY == 1) ? ~w_par_x : w_par_x;
    assign w_push      = w_last_stop && !w_frame_bad && !r_par_flag;

    // Receive FSM: bit timing, shift register, error flags and pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_flag   <= 1'b0;
            r_frame_flag <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state      <= S_DATA;
                            r_bit_cnt    <= '0;
                            r_par_flag   <= 1'b0;
                            r_frame_flag <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_timer    <= '0;
                        r_par_flag <= w_par_bad;
                        r_bit_cnt  <= '0;
                        r_state    <= S_STOP;
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (!w_bit) begin
                            r_frame_flag <= 1'b1;
                        end
                        if (w_last_stop) begin
                            if (w_frame_bad) begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end else begin
                                r_parity_err <= r_par_flag;
                                r_state      <= S_IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_WIDTH'(1);
                    end
                end
                S_BREAK: begin
                    r_timer <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = !w_empty && ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_rptr_nx = r_rptr + PW'(w_pop);
    assign w_head_nx = (w_wr && (w_rptr_nx == r_wptr)) ? r_shift
                                                        : r_mem[w_rptr_nx[AW-1:0]];

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= r_shift;
        end
    end

    // FIFO pointers, registered head word and overrun pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_out     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            r_rptr <= w_rptr_nx;
            r_out  <= w_head_nx;
        end
    end

    assign out        = r_out;
    assign valid      = !w_empty;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random frames against a queue-based model.
// DUT built as 8E2, 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int C     = 16;
    localparam int DB    = 8;
    localparam int SB    = 2;
    localparam int DEPTH = 4;
    localparam int NB    = DB + 1 + SB;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // line fall -> 2 sync flops + FSM entry, half bit, then NB full bits
    localparam int LAT = 3 + C / 2 + NB * C + MAJ;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_s = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] mq[$];
    ev_t        sched[$];
    bit         rdone;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(DB),
        .PARITY(2),
        .STOP_BITS(SB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .in(in_s),
        .out(out),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8E2 frame; optionally register its predicted outcome.
    task automatic send_frame(input logic [7:0] d, input logic pb,
                              input logic st1, input logic st2,
                              input bit sched_it);
        logic [11:0] bits;
        ev_t         ev;
        bits = {st2, st1, (^d) ^ pb, d, 1'b0};
        if (sched_it) begin
            ev.cyc  = cyc + LAT;
            ev.d    = d;
            ev.kind = (!st1 || !st2) ? 2 : (pb ? 1 : 0);
            sched.push_back(ev);
        end
        for (int j = 0; j < 12; j++) begin
            in_s = bits[j];
            repeat (C) tick();
        end
    endtask

    task automatic wait_valid(output int at, output logic [7:0] d);
        at = -1;
        d  = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid) begin
                at = cyc;
                d  = out;
                break;
            end
        end
    endtask

    // Reference model: FIFO as a queue, frame outcomes scheduled by the sender
    initial begin
        logic rdy_e;
        logic prev_v;
        logic ef;
        logic ep;
        logic eo;
        ev_t  ev;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            rdy_e = ready;
            @(negedge clk);
            ef = 1'b0;
            ep = 1'b0;
            eo = 1'b0;
            if (rst) begin
                mq.delete();
                sched.delete();
                chk("out_in_reset", {24'h0, out}, 32'h0);
                chk("busy_in_reset", {31'h0, busy}, 32'h0);
            end else begin
                if (prev_v && rdy_e) begin
                    void'(mq.pop_front());
                end
                while (sched.size() > 0 && sched[0].cyc <= cyc) begin
                    ev = sched.pop_front();
                    if (ev.kind == 2) begin
                        ef = 1'b1;
                    end else if (ev.kind == 1) begin
                        ep = 1'b1;
                    end else if (mq.size() < DEPTH) begin
                        mq.push_back(ev.d);
                    end else begin
                        eo = 1'b1;
                    end
                end
            end
            chk("valid", {31'h0, valid}, {31'h0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("out", {24'h0, out}, {24'h0, mq[0]});
            end
            chk("frame_err", {31'h0, frame_err}, {31'h0, ef});
            chk("parity_err", {31'h0, parity_err}, {31'h0, ep});
            chk("overrun", {31'h0, overrun}, {31'h0, eo});
            prev_v = (mq.size() > 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s;
        int         t;
        int         cnt;
        int         err;
        logic [7:0] d;
        logic [7:0] v77;

        rst   = 1'b1;
        in_s  = 1'b1;
        ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_out", {24'h0, out}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // 0xA5, consumer ready: one-cycle valid at a fixed latency
        ready = 1'b1;
        s = cyc;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_valid(t, d);
        join
        chk("a5_seen", {31'h0, t >= 0}, 32'h1);
        chk("a5_latency", t - s, 187 + MAJ);
        chk("a5_data", {24'h0, d}, 32'hA5);

        // 4-cycle low glitch while idle
        cnt = 0;
        in_s = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            tick();
            if (i == 3) in_s = 1'b1;
        end
        chk("glitch_busy_cycles", cnt, 8 + MAJ);

        // 0x3C with wrong parity bit, then a good 0x3C
        cnt = 0;
        fork
            send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
            repeat (192) begin
                @(negedge clk);
                if (parity_err) cnt++;
            end
        join
        chk("parity_err_count", cnt, 1);
        fork
            send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_valid(t, d);
        join
        chk("3c_seen", {31'h0, t >= 0}, 32'h1);
        chk("3c_data", {24'h0, d}, 32'h3C);

        // second stop bit low, line then held low for 5 bit times
        cnt = 0;
        fork
            send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
            repeat (192) begin
                @(negedge clk);
                if (frame_err) cnt++;
            end
        join
        chk("frame_err_count", cnt, 1);
        in_s = 1'b0;
        repeat (5 * C) tick();
        @(negedge clk);
        chk("break_busy", {31'h0, busy}, 32'h1);
        tick();
        in_s = 1'b1;
        repeat (2 * C) tick();
        @(negedge clk);
        chk("break_release_busy", {31'h0, busy}, 32'h0);
        tick();

        // five back-to-back words into a 4-deep FIFO with no consumer
        ready = 1'b0;
        cnt = 0;
        fork
            for (int v = 1; v <= 5; v++) begin
                send_frame(8'(v), 1'b0, 1'b1, 1'b1, 1'b1);
            end
            repeat (5 * 192) begin
                @(negedge clk);
                if (overrun) cnt++;
            end
        join
        chk("overrun_count", cnt, 1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("pop_valid", {31'h0, valid}, 32'h1);
            chk("pop_order", {24'h0, out}, i);
        end
        @(negedge clk);
        chk("drained_valid", {31'h0, valid}, 32'h0);
        tick();

        // reset in the middle of 0x77 with a word parked in the FIFO
        ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
        v77 = 8'h77;
        in_s = 1'b0;
        repeat (C) tick();
        for (int j = 0; j < 4; j++) begin
            in_s = v77[j];
            repeat (C) tick();
        end
        rst  = 1'b1;
        in_s = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'h0, valid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        repeat (4) tick();
        rst = 1'b0;
        repeat (4) tick();
        ready = 1'b1;
        fork
            send_frame(8'h12, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_valid(t, d);
        join
        chk("12_seen", {31'h0, t >= 0}, 32'h1);
        chk("12_data", {24'h0, d}, 32'h12);

        // random frames, errors, glitches and consumer stalls
        rdone = 1'b0;
        fork
            begin
                while (!rdone) begin
                    ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            begin
                for (int f = 0; f < 40; f++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        in_s = 1'b0;
                        repeat ($urandom_range(1, 6)) tick();
                        in_s = 1'b1;
                        repeat (C) tick();
                    end
                    err = $urandom_range(0, 7);
                    send_frame(8'($urandom_range(0, 255)), err == 0,
                               err != 1, err != 2, 1'b1);
                    if (err <= 2) begin
                        in_s = 1'b1;
                        repeat (C) tick();
                    end else begin
                        repeat ($urandom_range(0, 12)) tick();
                    end
                end
                rdone = 1'b1;
            end
        join
        ready = 1'b1;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
